minhash_index_selector: RTL and testbench



---
 rtl/minhash_index_selector.sv | 166 ++++++++++++++++
 tb/tb_minhash_index_selector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/minhash_index_selector.sv
// Bottom-k MinHash selector: scans a snapshot of base memory one k-mer per cycle and keeps
// the INDICES_COUNT smallest hashes (earliest position wins ties). Optional MINHASH_SKIP_N_EN.
module minhash_index_selector #(
  parameter int unsigned         KMER_LEN      = 4,
  parameter int unsigned         BASE_LEN      = 4,
  parameter int unsigned         ACTUAL_MEM    = 32,
  parameter int unsigned         MEM_LEN       = ACTUAL_MEM * BASE_LEN,
  parameter int unsigned         INDICES_COUNT = 2,
  parameter int unsigned         INDICE_LEN    = $clog2(ACTUAL_MEM),
  parameter int unsigned         HASH_LEN      = 16,
  parameter logic [HASH_LEN-1:0] HASH_MULT     = 16'h9E37
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [MEM_LEN-1:0]                         memory,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]   kmer_indices,
  output logic [$clog2(INDICES_COUNT+1)-1:0]         out_count
);

  localparam int unsigned KMER_W    = KMER_LEN * BASE_LEN;
  localparam int unsigned NUM_KMERS = ACTUAL_MEM - KMER_LEN + 1;
  localparam int unsigned CNT_W     = $clog2(INDICES_COUNT + 1);
  localparam int unsigned PROD_W    = KMER_W + HASH_LEN;
  localparam logic [INDICE_LEN-1:0] LAST_POS = INDICE_LEN'(NUM_KMERS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state;
  logic [INDICE_LEN-1:0]   pos;
  logic [BASE_LEN-1:0]     snap [ACTUAL_MEM];

  logic [HASH_LEN-1:0]     lh [INDICES_COUNT];
  logic [INDICE_LEN-1:0]   li [INDICES_COUNT];
  logic                    lv [INDICES_COUNT];

  logic [HASH_LEN-1:0]     nh [INDICES_COUNT];
  logic [INDICE_LEN-1:0]   ni [INDICES_COUNT];
  logic                    nv [INDICES_COUNT];

  logic [KMER_W-1:0]       kmer;
  logic [HASH_LEN-1:0]     hash;
  logic                    consider;
  logic [INDICES_COUNT-1:0] go;
  logic [CNT_W-1:0]        cnt_nxt;

  // Hash the current k-mer and compute the list after inserting it.
  always_comb begin
    kmer = '0;
    for (int b = 0; b < int'(KMER_LEN); b++) begin
      kmer[b*BASE_LEN +: BASE_LEN] = snap[pos + INDICE_LEN'(b)];
    end
    hash = HASH_LEN'(PROD_W'(kmer) * PROD_W'(HASH_MULT));

`ifdef MINHASH_SKIP_N_EN
    consider = 1'b1;
    for (int b = 0; b < int'(KMER_LEN); b++) begin
      if (kmer[b*BASE_LEN +: BASE_LEN] == '0) consider = 1'b0;
    end
`else
    consider = 1'b1;
`endif

    // List is sorted with valid entries first, so go[] is a thermometer code.
    go = '0;
    for (int i = 0; i < int'(INDICES_COUNT); i++) begin
      go[i] = consider && (!lv[i] || (lh[i] > hash));
    end

    for (int i = 0; i < int'(INDICES_COUNT); i++) begin
      nh[i] = lh[i];
      ni[i] = li[i];
      nv[i] = lv[i];
    end
    if (go[0]) begin
      nh[0] = hash;
      ni[0] = pos;
      nv[0] = 1'b1;
    end
    for (int i = 1; i < int'(INDICES_COUNT); i++) begin
      if (go[i]) begin
        if (go[i-1]) begin
          nh[i] = lh[i-1];
          ni[i] = li[i-1];
          nv[i] = lv[i-1];
        end else begin
          nh[i] = hash;
          ni[i] = pos;
          nv[i] = 1'b1;
        end
      end
    end

    cnt_nxt = '0;
    for (int i = 0; i < int'(INDICES_COUNT); i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(nv[i]);
    end
  end

  // Control FSM, list registers and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pos          <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      kmer_indices <= '0;
      out_count    <= '0;
      for (int i = 0; i < int'(INDICES_COUNT); i++) begin
        lh[i] <= '0;
        li[i] <= '0;
        lv[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < int'(ACTUAL_MEM); j++) begin
              snap[j] <= memory[j*BASE_LEN +: BASE_LEN];
            end
            for (int i = 0; i < int'(INDICES_COUNT); i++) begin
              lh[i] <= '0;
              li[i] <= '0;
              lv[i] <= 1'b0;
            end
            pos   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < int'(INDICES_COUNT); i++) begin
            lh[i] <= nh[i];
            li[i] <= ni[i];
            lv[i] <= nv[i];
          end
          pos <= pos + INDICE_LEN'(1);
          if (pos == LAST_POS) begin
            for (int i = 0; i < int'(INDICES_COUNT); i++) begin
              kmer_indices[i] <= nv[i] ? ni[i] : '0;
            end
            out_count <= cnt_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minhash_index_selector.sv
// Directed bench for minhash_index_selector: one DUT with HASH_MULT=1, one with the default multiplier.
module tb_minhash_index_selector;

  localparam int MEM_LEN = 128;
  localparam int NK      = 29;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [MEM_LEN-1:0] memory;
  logic               out_ready;

  logic               busy1, valid1, busy2, valid2;
  logic [1:0][4:0]    idx1, idx2;
  logic [1:0]         cnt1, cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  minhash_index_selector #(.HASH_MULT(16'h0001)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .memory(memory),
    .busy(busy1), .out_valid(valid1), .out_ready(out_ready),
    .kmer_indices(idx1), .out_count(cnt1)
  );

  minhash_index_selector dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .memory(memory),
    .busy(busy2), .out_valid(valid2), .out_ready(out_ready),
    .kmer_indices(idx2), .out_count(cnt2)
  );

  function automatic logic [MEM_LEN-1:0] fill(input logic [3:0] b);
    logic [MEM_LEN-1:0] m;
    for (int j = 0; j < 32; j++) m[j*4 +: 4] = b;
    return m;
  endfunction

  function automatic logic [MEM_LEN-1:0] pattern2();
    logic [MEM_LEN-1:0] m;
    m = fill(4'h8);
    m[20*4 +: 4] = 4'h1;
    return m;
  endfunction

  // Brute-force reference: pick the two smallest (hash, position) pairs.
  task automatic model(input logic [MEM_LEN-1:0] m, input logic [15:0] mult,
                       output logic [9:0] idx, output logic [1:0] cnt);
    logic [15:0] h [NK];
    logic        ok [NK];
    int          b0, b1;
    for (int p = 0; p < NK; p++) begin
      logic [15:0] k;
      k = m[p*4 +: 16];
      h[p] = 16'(32'(k) * 32'(mult));
      ok[p] = 1'b1;
`ifdef MINHASH_SKIP_N_EN
      for (int b = 0; b < 4; b++) if (k[b*4 +: 4] == 4'h0) ok[p] = 1'b0;
`endif
    end
    b0 = -1;
    for (int p = 0; p < NK; p++)
      if (ok[p] && (b0 < 0 || h[p] < h[b0])) b0 = p;
    b1 = -1;
    for (int p = 0; p < NK; p++)
      if (ok[p] && p != b0 && (b1 < 0 || h[p] < h[b1])) b1 = p;
    idx = {(b1 >= 0) ? 5'(b1) : 5'd0, (b0 >= 0) ? 5'(b0) : 5'd0};
    cnt = 2'((b0 >= 0 ? 1 : 0) + (b1 >= 0 ? 1 : 0));
  endtask

  task automatic do_start(input logic [MEM_LEN-1:0] m);
    memory = m;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    repeat (NK - 1) @(posedge clk);
    #1;
    n_checks++;
    if (valid1 !== 1'b0) begin
      n_fail++; $display("FAIL %s early_valid: got %b want 0", name, valid1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid1 !== 1'b1 || valid2 !== 1'b1) begin
      n_fail++; $display("FAIL %s valid_latency: got %b/%b want 1/1", name, valid1, valid2);
    end
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL %s accept: valid=%b busy=%b want 0/0", name, valid1, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; memory = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0 || idx1 !== 10'd0 || cnt1 !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: busy=%b valid=%b idx=%h cnt=%0d want all 0",
                         busy1, valid1, idx1, cnt1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    do_start(fill(4'h1));
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL ones_busy: got %b want 1", busy1);
    end
    wait_done("ones");
    n_checks++;
    if (idx1 !== {5'd1, 5'd0} || cnt1 !== 2'd2) begin
      n_fail++; $display("FAIL ones_result: idx=%h cnt=%0d want %h 2", idx1, cnt1, {5'd1, 5'd0});
    end
    accept("ones");
  endtask

  task automatic test_single_low();
    do_start(pattern2());
    wait_done("pat2");
    n_checks++;
    if (idx1 !== {5'd18, 5'd17} || cnt1 !== 2'd2) begin
      n_fail++; $display("FAIL pat2_result: idx=%h cnt=%0d want %h 2", idx1, cnt1, {5'd18, 5'd17});
    end
    accept("pat2");
  endtask

  task automatic test_all_n();
    logic [9:0] ei;
    logic [1:0] ec;
`ifdef MINHASH_SKIP_N_EN
    ei = 10'd0; ec = 2'd0;
`else
    ei = {5'd1, 5'd0}; ec = 2'd2;
`endif
    do_start(fill(4'h0));
    wait_done("alln");
    n_checks++;
    if (idx1 !== ei || cnt1 !== ec) begin
      n_fail++; $display("FAIL alln_result: idx=%h cnt=%0d want %h %0d", idx1, cnt1, ei, ec);
    end
    accept("alln");
  endtask

  task automatic test_backpressure();
    do_start(pattern2());
    wait_done("bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start = 1'b1; memory = fill(4'h1); end
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (valid1 !== 1'b1 || busy1 !== 1'b1 || idx1 !== {5'd18, 5'd17} || cnt1 !== 2'd2) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b busy=%b idx=%h cnt=%0d want 1 1 %h 2",
                           c, valid1, busy1, idx1, cnt1, {5'd18, 5'd17});
      end
    end
    // start coinciding with the accepting edge must be ignored
    start = 1'b1;
    accept("bp");
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_restart: busy=%b valid=%b want 0/0", busy1, valid1);
    end
  endtask

  task automatic test_reset_mid_scan();
    do_start(fill(4'h1));
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0 || idx1 !== 10'd0 || cnt1 !== 2'd0) begin
      n_fail++; $display("FAIL midreset_clear: busy=%b valid=%b idx=%h cnt=%0d want 0",
                         busy1, valid1, idx1, cnt1);
    end
    rst_n = 1'b1;
    do_start(pattern2());
    wait_done("midreset");
    n_checks++;
    if (idx1 !== {5'd18, 5'd17} || cnt1 !== 2'd2) begin
      n_fail++; $display("FAIL midreset_result: idx=%h cnt=%0d want %h 2", idx1, cnt1, {5'd18, 5'd17});
    end
    accept("midreset");
  endtask

  task automatic test_random();
    logic [MEM_LEN-1:0] m;
    logic [9:0]         ei1, ei2;
    logic [1:0]         ec1, ec2;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < MEM_LEN / 32; w++) m[w*32 +: 32] = $urandom;
      if (r == 3) m[40 +: 16] = m[0 +: 16];  // force a duplicated k-mer
      model(m, 16'h0001, ei1, ec1);
      model(m, 16'h9E37, ei2, ec2);
      do_start(m);
      wait_done("rand");
      n_checks++;
      if (idx1 !== ei1 || cnt1 !== ec1) begin
        n_fail++; $display("FAIL rand%0d_mult1: idx=%h cnt=%0d want %h %0d", r, idx1, cnt1, ei1, ec1);
      end
      n_checks++;
      if (idx2 !== ei2 || cnt2 !== ec2) begin
        n_fail++; $display("FAIL rand%0d_mult9e37: idx=%h cnt=%0d want %h %0d", r, idx2, cnt2, ei2, ec2);
      end
      accept("rand");
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_low();
    test_all_n();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
